spi_sram_responder: RTL and testbench
=====================================

// Module: spi_sram_responder
// PURPOSE
//  Synthesizable SPI-target SRAM (23LC512-style, mode 0, sequential mode only); the responder end of spi_memory_controller.
//  Oversamples SCLK/CS_n/MOSI on clk; serves READ/WRITE/RDMR against an internal byte array.
//  Provides a backdoor load/read port so benches can preload programs and check results.
//  Used as the FPGA/gate-level replacement for the behavioural SRAM model behind spi_cs_ram_n.
// PARAMETERS
//  ADDR_W   10    array index width; DEPTH = 2**ADDR_W bytes; upper SPI address bits ignored
//  SYNC_STG 2     synchronizer flops on spi_sclk, spi_cs_n, spi_mosi (>=2)
// PORTS
//  clk          in   1       system clock; requires f_sclk <= f_clk/8
//  reset_n      in   1       asynchronous, active-low reset
//  spi_cs_n     in   1       chip select, active low
//  spi_sclk     in   1       SPI clock from initiator
//  spi_mosi     in   1       serial data in
//  spi_miso     out  1       serial data out
//  spi_miso_oe  out  1       MISO output enable (1 only while driving data)
//  load_en      in   1       backdoor write strobe
//  load_addr    in   ADDR_W  backdoor write address
//  load_data    in   8       backdoor write data
//  rd_addr      in   ADDR_W  backdoor read address
//  rd_data      out  8       mem[rd_addr], combinational
//  busy         out  1       synchronized CS active
//  wr_pulse     out  1       1-clk pulse per byte committed by SPI
//  cmd_err      out  1       1-clk pulse on unsupported opcode
// BEHAVIOUR
//  Reset: spi_miso=0, spi_miso_oe=0, busy=0, wr_pulse=0, cmd_err=0, FSM=IDLE, counters 0. Array contents NOT reset.
//  Edges are detected on synchronized SCLK; rise = sample MOSI (MSB first), fall = shift MISO.
//  FSM: IDLE -(CS low)-> CMD -(8 bits)-> ADDR_HI -(8)-> ADDR_LO -(8)-> READ|WRITE; RDMR -> MODE; bad opcode -> IGNORE.
//   Opcodes: 0x03 READ, 0x02 WRITE, 0x05 RDMR (returns 0x40 on every byte). 0x01 WRMR is accepted and data discarded (WRITE-less sink).
//   Any other opcode: cmd_err pulse, IGNORE until CS high; MISO not driven.
//  Synchronized CS high in any state -> IDLE within 1 clk; bit counter cleared; partial byte discarded; miso_oe=0.
//  Address = {ADDR_HI, ADDR_LO}[ADDR_W-1:0]; increments after each data byte; wraps DEPTH-1 -> 0.
//  READ: mem[addr] fetched on the 8th address rise; bit7 driven on the following SCLK fall (valid before first data rise).
//   Next byte is prefetched on each byte's 8th rise; the stream continues until CS high.
//  WRITE: byte committed to mem on its 8th rise (+ sync latency); wr_pulse that clk; then address increments.
//  spi_miso_oe=1 only in READ/MODE from the first data fall until CS high.
//  Same-clk SPI commit and load_en: both written if addresses differ; at same address load_data wins.
//  rd_data reflects any write on the following clk.
//  Reset asserted mid-transfer: immediate return to reset state; remaining SCLKs are ignored until CS goes high then low again.
//  CS low with SCLK already high at entry: the first edge counted is the next rise only.
// TESTING
//  1 SCLK=clk/8: CS low, 02 00 12 A5 5A, CS high -> mem[0x012]=A5, mem[0x013]=5A, 2 wr_pulse, rd_data checks.
//  2 load 0x3FF=C3, 0x000=3C; READ 03 03 FF + 16 clocks -> MISO bytes C3,3C (wrap), oe high only in data phase.
//  3 opcode 9F + 3 bytes -> cmd_err=1 for exactly 1 clk, oe=0, no mem change, next READ works.
//  4 WRITE 02 00 20 then 5 bits, CS high -> mem[0x020] unchanged, FSM IDLE, new transaction works.
//  5 RDMR 05 + 2 bytes -> MISO 40,40; load_en and SPI write to same addr in same clk -> load_data stored.
//  6 reset_n low mid-READ -> miso=0, oe=0, busy=0 async; after release + new CS, READ correct.

Source files
------------

// File: rtl/spi_sram_responder.sv
// spi_sram_responder
//   SPI-target byte SRAM (23LC512-like, mode 0, sequential mode only).
//   SCLK/CS_n/MOSI are oversampled on clk; SCLK rise samples MOSI (MSB first),
//   SCLK fall shifts MISO. Opcodes: 03 READ, 02 WRITE, 05 RDMR (0x40 forever),
//   01 WRMR (data swallowed). Anything else pulses cmd_err and is ignored.
// Ports
//   clk, reset_n                 system clock (f_sclk <= f_clk/8), async active-low reset
//   spi_cs_n/sclk/mosi           SPI inputs from the initiator
//   spi_miso, spi_miso_oe        SPI data out and its enable (READ/RDMR data phase only)
//   load_en/addr/data            backdoor write port (wins over SPI at the same address)
//   rd_addr, rd_data             backdoor combinational read
//   busy                         synchronized CS active
//   wr_pulse                     1-clk pulse per SPI byte committed
//   cmd_err                      1-clk pulse on unsupported opcode
`timescale 1ns/1ps
module spi_sram_responder #(
    parameter int ADDR_W   = 10,  // 9..16
    parameter int SYNC_STG = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              spi_cs_n,
    input  logic              spi_sclk,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [7:0]        load_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              busy,
    output logic              wr_pulse,
    output logic              cmd_err
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_ADDR_HI, S_ADDR_LO, S_READ, S_WRITE, S_MODE, S_SINK, S_IGNORE
    } state_t;

    logic [7:0]          mem [DEPTH];
    logic [SYNC_STG-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                sclk_s, cs_s, mosi_s, sclk_d;
    logic                rise, fall, armed, is_rd;
    state_t              state;
    logic [2:0]          bit_cnt;
    logic [7:0]          shreg, tx;
    logic [ADDR_W-9:0]   addr_hi;
    logic [ADDR_W-1:0]   addr;
    logic [7:0]          byte_in;
    logic [ADDR_W-1:0]   full_addr;
    logic                wr_fire;

    // The CS chain resets to "low": after reset the responder stays disarmed
    // until it has actually seen CS high, so a transfer cut by reset is
    // ignored to its end rather than re-entered mid-stream.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STG-2:0], spi_sclk};
            cs_sync   <= {cs_sync[SYNC_STG-2:0], spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STG-2:0], spi_mosi};
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STG-1];
    assign cs_s      = cs_sync[SYNC_STG-1];
    assign mosi_s    = mosi_sync[SYNC_STG-1];
    assign rise      = sclk_s & ~sclk_d;
    assign fall      = ~sclk_s & sclk_d;
    assign byte_in   = {shreg[6:0], mosi_s};
    assign full_addr = {addr_hi, byte_in};
    assign wr_fire   = ~cs_s && (state == S_WRITE) && rise && (bit_cnt == 3'd7);
    assign rd_data   = mem[rd_addr];

    // Backdoor load is written last so it wins a same-clk, same-address clash.
    always_ff @(posedge clk) begin
        if (wr_fire) mem[addr] <= byte_in;
        if (load_en) mem[load_addr] <= load_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            tx          <= '0;
            addr_hi     <= '0;
            addr        <= '0;
            is_rd       <= 1'b0;
            armed       <= 1'b0;
            sclk_d      <= 1'b0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            busy        <= 1'b0;
            wr_pulse    <= 1'b0;
            cmd_err     <= 1'b0;
        end else begin
            sclk_d   <= sclk_s;
            wr_pulse <= wr_fire;
            cmd_err  <= 1'b0;
            if (cs_s) begin
                state       <= S_IDLE;
                bit_cnt     <= '0;
                spi_miso    <= 1'b0;
                spi_miso_oe <= 1'b0;
                busy        <= 1'b0;
                armed       <= 1'b1;
            end else if (state == S_IDLE) begin
                // Rises seen in IDLE are dropped: if SCLK is already high at
                // CS entry, the first counted edge is the next rise.
                if (armed) begin
                    state   <= S_CMD;
                    bit_cnt <= '0;
                    busy    <= 1'b1;
                end
            end else begin
                if (rise) begin
                    shreg   <= byte_in;
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        case (state)
                            S_CMD: begin
                                case (byte_in)
                                    8'h03: begin state <= S_ADDR_HI; is_rd <= 1'b1; end
                                    8'h02: begin state <= S_ADDR_HI; is_rd <= 1'b0; end
                                    8'h05: begin state <= S_MODE; tx <= 8'h40; end
                                    8'h01: state <= S_SINK;
                                    default: begin state <= S_IGNORE; cmd_err <= 1'b1; end
                                endcase
                            end
                            S_ADDR_HI: begin
                                addr_hi <= byte_in[ADDR_W-9:0];
                                state   <= S_ADDR_LO;
                            end
                            S_ADDR_LO: begin
                                // READ keeps addr one ahead: it is the next prefetch.
                                if (is_rd) begin
                                    tx    <= mem[full_addr];
                                    addr  <= full_addr + ADDR_ONE;
                                    state <= S_READ;
                                end else begin
                                    addr  <= full_addr;
                                    state <= S_WRITE;
                                end
                            end
                            S_READ: begin
                                tx   <= mem[addr];
                                addr <= addr + ADDR_ONE;
                            end
                            S_WRITE: addr <= addr + ADDR_ONE;
                            S_MODE:  tx <= 8'h40;
                            default: ;
                        endcase
                    end
                end
                if (fall && (state == S_READ || state == S_MODE)) begin
                    spi_miso    <= tx[7];
                    tx          <= {tx[6:0], 1'b0};
                    spi_miso_oe <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_sram_responder.sv
`timescale 1ns/1ps
module tb_spi_sram_responder;
    localparam int AW = 10;

    logic          clk = 1'b0, reset_n = 1'b0;
    logic          spi_cs_n = 1'b1, spi_sclk = 1'b0, spi_mosi = 1'b0;
    logic          load_en = 1'b0;
    logic [AW-1:0] load_addr = '0, rd_addr = '0;
    logic [7:0]    load_data = '0;
    logic          spi_miso, spi_miso_oe, busy, wr_pulse, cmd_err;
    logic [7:0]    rd_data;

    int n_tests = 0, n_fail = 0;
    int wr_cnt = 0, err_cnt = 0;

    spi_sram_responder #(.ADDR_W(AW), .SYNC_STG(2)) dut (
        .clk(clk), .reset_n(reset_n), .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy),
        .wr_pulse(wr_pulse), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_pulse) wr_cnt <= wr_cnt + 1;
        if (cmd_err)  err_cnt <= err_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic peek(input logic [AW-1:0] a, output logic [7:0] d);
        @(negedge clk);
        rd_addr = a;
        #1 d = rd_data;
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [7:0] d);
        @(negedge clk);
        load_en = 1'b1; load_addr = a; load_data = d;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    // nb bits MSB-first, SCLK = clk/8. Optionally fires load_en on exactly the
    // clk the responder commits the last bit of this byte.
    task automatic spi_xfer(input logic [7:0] d, input int nb, input bit ld,
                            input logic [AW-1:0] la, input logic [7:0] ldd,
                            output logic [7:0] rx, output int oe_n);
        rx = '0; oe_n = 0;
        for (int i = 7; i > 7 - nb; i--) begin
            spi_mosi = d[i];
            repeat (4) @(negedge clk);
            spi_sclk = 1'b1;
            rx = {rx[6:0], spi_miso};
            if (spi_miso_oe) oe_n++;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (ld && i == 0) begin
                    load_en = (k == 1); load_addr = la; load_data = ldd;
                end
            end
            spi_sclk = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] d, output logic [7:0] rx, output int oe_n);
        spi_xfer(d, 8, 1'b0, '0, '0, rx, oe_n);
    endtask

    task automatic cs_lo();
        spi_cs_n = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic cs_hi();
        repeat (4) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        logic [7:0] rx, d;
        int oe, oe_sum, w0, e0;

        // reset state
        #1;
        check("rst_miso", spi_miso, 0);
        check("rst_oe", spi_miso_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_wr_pulse", wr_pulse, 0);
        check("rst_cmd_err", cmd_err, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // 1: WRITE two bytes
        w0 = wr_cnt;
        cs_lo();
        check("t1_busy_on", busy, 1);
        spi_byte(8'h02, rx, oe); spi_byte(8'h00, rx, oe); spi_byte(8'h12, rx, oe);
        spi_byte(8'hA5, rx, oe); spi_byte(8'h5A, rx, oe);
        cs_hi();
        check("t1_busy_off", busy, 0);
        check("t1_wr_pulses", wr_cnt - w0, 2);
        peek(10'h012, d); check("t1_mem012", d, 8'hA5);
        peek(10'h013, d); check("t1_mem013", d, 8'h5A);

        // 2: READ with address wrap
        load(10'h3FF, 8'hC3);
        load(10'h000, 8'h3C);
        peek(10'h3FF, d); check("t2_load3ff", d, 8'hC3);
        cs_lo();
        oe_sum = 0;
        spi_byte(8'h03, rx, oe); oe_sum += oe;
        spi_byte(8'h03, rx, oe); oe_sum += oe;
        spi_byte(8'hFF, rx, oe); oe_sum += oe;
        check("t2_oe_cmd_phase", oe_sum, 0);
        spi_byte(8'h00, rx, oe); check("t2_byte0", rx, 8'hC3); check("t2_oe_data0", oe, 8);
        spi_byte(8'h00, rx, oe); check("t2_byte1_wrap", rx, 8'h3C); check("t2_oe_data1", oe, 8);
        cs_hi();
        check("t2_oe_after_cs", spi_miso_oe, 0);

        // 3: unsupported opcode
        e0 = err_cnt; w0 = wr_cnt;
        cs_lo();
        oe_sum = 0;
        spi_byte(8'h9F, rx, oe); oe_sum += oe;
        spi_byte(8'h00, rx, oe); oe_sum += oe;
        spi_byte(8'h12, rx, oe); oe_sum += oe;
        spi_byte(8'hEE, rx, oe); oe_sum += oe;
        cs_hi();
        check("t3_cmd_err_1clk", err_cnt - e0, 1);
        check("t3_oe_never", oe_sum, 0);
        check("t3_no_write", wr_cnt - w0, 0);
        peek(10'h012, d); check("t3_mem_kept", d, 8'hA5);
        cs_lo();
        spi_byte(8'h03, rx, oe); spi_byte(8'h00, rx, oe); spi_byte(8'h12, rx, oe);
        spi_byte(8'h00, rx, oe); check("t3_read_after", rx, 8'hA5);
        spi_byte(8'h00, rx, oe); check("t3_read_after_inc", rx, 8'h5A);
        cs_hi();

        // 4: partial byte discarded
        load(10'h020, 8'h11);
        w0 = wr_cnt;
        cs_lo();
        spi_byte(8'h02, rx, oe); spi_byte(8'h00, rx, oe); spi_byte(8'h20, rx, oe);
        spi_xfer(8'hFF, 5, 1'b0, '0, '0, rx, oe);
        cs_hi();
        check("t4_no_wr_pulse", wr_cnt - w0, 0);
        check("t4_idle", busy, 0);
        peek(10'h020, d); check("t4_mem_unchanged", d, 8'h11);
        cs_lo();
        spi_byte(8'h02, rx, oe); spi_byte(8'h00, rx, oe); spi_byte(8'h20, rx, oe);
        spi_byte(8'h77, rx, oe);
        cs_hi();
        peek(10'h020, d); check("t4_new_write", d, 8'h77);

        // 5: RDMR and same-clk backdoor/SPI writes
        cs_lo();
        spi_byte(8'h05, rx, oe);
        spi_byte(8'h00, rx, oe); check("t5_rdmr0", rx, 8'h40); check("t5_rdmr0_oe", oe, 8);
        spi_byte(8'h00, rx, oe); check("t5_rdmr1", rx, 8'h40);
        cs_hi();
        w0 = wr_cnt;
        cs_lo();
        spi_byte(8'h02, rx, oe); spi_byte(8'h00, rx, oe); spi_byte(8'h30, rx, oe);
        spi_xfer(8'hAA, 8, 1'b1, 10'h100, 8'h99, rx, oe);
        spi_xfer(8'hBB, 8, 1'b1, 10'h031, 8'hCC, rx, oe);
        cs_hi();
        check("t5_wr_pulses", wr_cnt - w0, 2);
        peek(10'h030, d); check("t5_spi_diff_addr", d, 8'hAA);
        peek(10'h100, d); check("t5_load_diff_addr", d, 8'h99);
        peek(10'h031, d); check("t5_same_addr_load_wins", d, 8'hCC);

        // 6: reset mid-READ
        load(10'h050, 8'h81);
        load(10'h051, 8'h7E);
        cs_lo();
        spi_byte(8'h03, rx, oe); spi_byte(8'h00, rx, oe); spi_byte(8'h50, rx, oe);
        spi_xfer(8'h00, 7, 1'b0, '0, '0, rx, oe);
        repeat (4) @(negedge clk);
        check("t6_pre_miso", spi_miso, 1);
        check("t6_pre_oe", spi_miso_oe, 1);
        check("t6_pre_busy", busy, 1);
        #2 reset_n = 1'b0;
        #1;
        check("t6_rst_miso", spi_miso, 0);
        check("t6_rst_oe", spi_miso_oe, 0);
        check("t6_rst_busy", busy, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        w0 = wr_cnt;
        oe_sum = 0;
        spi_byte(8'h02, rx, oe); oe_sum += oe;
        spi_byte(8'h00, rx, oe); oe_sum += oe;
        check("t6_ignored_oe", oe_sum, 0);
        check("t6_ignored_busy", busy, 0);
        check("t6_ignored_wr", wr_cnt - w0, 0);
        cs_hi();
        cs_lo();
        spi_byte(8'h03, rx, oe); spi_byte(8'h00, rx, oe); spi_byte(8'h50, rx, oe);
        spi_byte(8'h00, rx, oe); check("t6_read0", rx, 8'h81);
        spi_byte(8'h00, rx, oe); check("t6_read1", rx, 8'h7E);
        cs_hi();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
